// File: rtl/cpu_operand_fetch_pkg.sv
// Shared types for the operand/effective-address sequencer.
//   addrmode_t   : 3-bit addressing mode as presented on the mode input.
//   fetchstate_t : sequencer state encoding (the top mirrors it as localparams).
//   operand_bytes: number of operand bytes that follow the opcode for a mode.
//   uses_x/uses_y: which index register a mode adds to its base address.
package cpu_operand_fetch_pkg;

  typedef enum logic [2:0] {
    AM_IMP  = 3'd0,
    AM_IMM  = 3'd1,
    AM_ZP   = 3'd2,
    AM_ZPX  = 3'd3,
    AM_ZPY  = 3'd4,
    AM_ABS  = 3'd5,
    AM_ABSX = 3'd6,
    AM_ABSY = 3'd7
  } addrmode_t;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'd0,
    FS_FETCH_LO = 3'd1,
    FS_FETCH_HI = 3'd2,
    FS_INDEX    = 3'd3,
    FS_FIX_PAGE = 3'd4,
    FS_READ_OP  = 3'd5,
    FS_DONE     = 3'd6
  } fetchstate_t;

  function automatic logic [1:0] operand_bytes(input addrmode_t m);
    case (m)
      AM_IMP:                        return 2'd0;
      AM_IMM, AM_ZP, AM_ZPX, AM_ZPY: return 2'd1;
      default:                       return 2'd2;
    endcase
  endfunction

  function automatic logic uses_x(input addrmode_t m);
    return (m == AM_ZPX) || (m == AM_ABSX);
  endfunction

  function automatic logic uses_y(input addrmode_t m);
    return (m == AM_ZPY) || (m == AM_ABSY);
  endfunction

endpackage

// File: rtl/cpu_operand_fetch_if.sv
// Request/result and memory-bus bundle of the operand fetch sequencer.
//   Request : start, mode, noRead, pcIn, xReg, yReg      (environment -> fetch)
//   Result  : busy, done, operand, effAddr, pcOut, pageCross, busErr
//   Memory  : memReq, memAddr (fetch -> bus); memAck, dataRd (bus -> fetch)
// Modports: master = the fetch sequencer, slave = decode stage + memory arbiter.
interface cpu_operand_fetch_if
  import cpu_operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
) ();

  logic              start;
  addrmode_t         mode;
  logic              noRead;
  logic [ADDR_W-1:0] pcIn;
  logic [DATA_W-1:0] xReg;
  logic [DATA_W-1:0] yReg;

  logic              busy;
  logic              done;
  logic [DATA_W-1:0] operand;
  logic [ADDR_W-1:0] effAddr;
  logic [ADDR_W-1:0] pcOut;
  logic              pageCross;
  logic              busErr;

  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [DATA_W-1:0] dataRd;

  modport master (
    input  start, mode, noRead, pcIn, xReg, yReg, memAck, dataRd,
    output busy, done, operand, effAddr, pcOut, pageCross, busErr, memReq, memAddr
  );

  modport slave (
    output start, mode, noRead, pcIn, xReg, yReg, memAck, dataRd,
    input  busy, done, operand, effAddr, pcOut, pageCross, busErr, memReq, memAddr
  );

endinterface

// File: rtl/cpu_operand_fetch_index_adder.sv
// Combinational effective-address adder.
//   i_lo, i_hi   : base address bytes (i_hi ignored in zero-page mode)
//   i_idx        : index value (0 when the mode is not indexed)
//   i_zero_page  : 1 = result stays in page 0, wrapping within the low byte
//   o_eff_addr   : effective address
//   o_page_cross : indexed absolute result landed in a different page than i_hi
module cpu_operand_fetch_index_adder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic [DATA_W-1:0] i_lo,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_idx,
  input  logic              i_zero_page,
  output logic [ADDR_W-1:0] o_eff_addr,
  output logic              o_page_cross
);

  logic [DATA_W-1:0] w_zp_lo;
  logic [ADDR_W-1:0] w_abs;

  // The DATA_W-wide sum discards the carry, which is the zero-page wrap.
  assign w_zp_lo = i_lo + i_idx;
  assign w_abs   = {i_hi, i_lo} + ADDR_W'(i_idx);

  always_comb begin
    if (i_zero_page) begin
      o_eff_addr   = ADDR_W'(w_zp_lo);
      o_page_cross = 1'b0;
    end else begin
      o_eff_addr   = w_abs;
      o_page_cross = (w_abs[ADDR_W-1:DATA_W] != i_hi);
    end
  end

endmodule

// File: rtl/cpu_operand_fetch.sv
// Multi-cycle operand / effective-address sequencer.
//   cpuClk : clock
//   reset  : asynchronous active-high reset; aborts any transaction in flight
//   bus    : cpu_operand_fetch_if.master -- request inputs, result outputs and
//            the req/ack memory read port
// ADDR_W must equal 2*DATA_W (an address is one hi byte and one lo byte).
// Every bus wait is bounded by ACK_TIMEOUT cycles; a timeout reports busErr with done.
module cpu_operand_fetch
  import cpu_operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned PAGE_PENALTY = 1,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input logic                 cpuClk,
  input logic                 reset,
  cpu_operand_fetch_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
  // Count value seen on the last permitted wait cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE     = FS_IDLE;
  localparam logic [2:0] ST_FETCH_LO = FS_FETCH_LO;
  localparam logic [2:0] ST_FETCH_HI = FS_FETCH_HI;
  localparam logic [2:0] ST_INDEX    = FS_INDEX;
  localparam logic [2:0] ST_FIX_PAGE = FS_FIX_PAGE;
  localparam logic [2:0] ST_READ_OP  = FS_READ_OP;
  localparam logic [2:0] ST_DONE     = FS_DONE;

  logic [2:0]        r_state,      w_state_d;
  addrmode_t         r_mode,       w_mode_d;
  logic              r_no_read,    w_no_read_d;
  logic [ADDR_W-1:0] r_pc,         w_pc_d;
  logic [DATA_W-1:0] r_x,          w_x_d;
  logic [DATA_W-1:0] r_y,          w_y_d;
  logic [DATA_W-1:0] r_lo,         w_lo_d;
  logic [WAIT_W-1:0] r_wait,       w_wait_d;
  logic [DATA_W-1:0] r_operand,    w_operand_d;
  logic [ADDR_W-1:0] r_eff_addr,   w_eff_addr_d;
  logic [ADDR_W-1:0] r_pc_out,     w_pc_out_d;
  logic              r_page_cross, w_page_cross_d;
  logic              r_bus_err,    w_bus_err_d;

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_idx_eff;
  logic              w_idx_cross;
  logic [2:0]        w_after_addr;

  always_comb begin
    if (uses_x(r_mode)) begin
      w_idx = r_x;
    end else if (uses_y(r_mode)) begin
      w_idx = r_y;
    end else begin
      w_idx = '0;
    end
  end

  // hi comes straight off the bus so FETCH_HI can latch the final address on its ack.
  cpu_operand_fetch_index_adder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_index_adder (
    .i_lo         (r_lo),
    .i_hi         (bus.dataRd),
    .i_idx        (w_idx),
    .i_zero_page  (r_state == ST_INDEX),
    .o_eff_addr   (w_idx_eff),
    .o_page_cross (w_idx_cross)
  );

  // Stores need only the address, so they finish as soon as it is known.
  assign w_after_addr = r_no_read ? ST_DONE : ST_READ_OP;

  always_comb begin
    w_state_d      = r_state;
    w_mode_d       = r_mode;
    w_no_read_d    = r_no_read;
    w_pc_d         = r_pc;
    w_x_d          = r_x;
    w_y_d          = r_y;
    w_lo_d         = r_lo;
    w_wait_d       = r_wait;
    w_operand_d    = r_operand;
    w_eff_addr_d   = r_eff_addr;
    w_pc_out_d     = r_pc_out;
    w_page_cross_d = r_page_cross;
    w_bus_err_d    = r_bus_err;
    w_req          = 1'b0;
    w_addr         = '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_mode_d       = bus.mode;
          w_no_read_d    = bus.noRead;
          w_pc_d         = bus.pcIn;
          w_x_d          = bus.xReg;
          w_y_d          = bus.yReg;
          w_lo_d         = '0;
          w_wait_d       = '0;
          w_operand_d    = '0;
          w_eff_addr_d   = '0;
          w_page_cross_d = 1'b0;
          w_bus_err_d    = 1'b0;
          w_pc_out_d     = bus.pcIn + ADDR_W'(operand_bytes(bus.mode));
          w_state_d      = (bus.mode == AM_IMP) ? ST_DONE : ST_FETCH_LO;
        end
      end

      ST_FETCH_LO: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (bus.memAck) begin
          w_wait_d = '0;
          w_lo_d   = bus.dataRd;
          case (r_mode)
            AM_IMM: begin
              w_operand_d = bus.dataRd;
              w_state_d   = ST_DONE;
            end
            AM_ZP: begin
              w_eff_addr_d = ADDR_W'(bus.dataRd);
              w_state_d    = w_after_addr;
            end
            AM_ZPX, AM_ZPY: w_state_d = ST_INDEX;
            default:        w_state_d = ST_FETCH_HI;
          endcase
        end else if (r_wait == WAIT_LAST) begin
          w_wait_d    = '0;
          w_bus_err_d = 1'b1;
          w_operand_d = '0;
          w_state_d   = ST_DONE;
        end else begin
          w_wait_d = r_wait + 1'b1;
        end
      end

      ST_FETCH_HI: begin
        w_req  = 1'b1;
        w_addr = r_pc + ADDR_W'(1);
        if (bus.memAck) begin
          w_wait_d       = '0;
          w_eff_addr_d   = w_idx_eff;
          w_page_cross_d = w_idx_cross;
          w_state_d      = (w_idx_cross && (PAGE_PENALTY != 0)) ? ST_FIX_PAGE : w_after_addr;
        end else if (r_wait == WAIT_LAST) begin
          w_wait_d    = '0;
          w_bus_err_d = 1'b1;
          w_operand_d = '0;
          w_state_d   = ST_DONE;
        end else begin
          w_wait_d = r_wait + 1'b1;
        end
      end

      ST_INDEX: begin
        w_eff_addr_d   = w_idx_eff;
        w_page_cross_d = 1'b0;
        w_state_d      = w_after_addr;
      end

      ST_FIX_PAGE: begin
        w_state_d = w_after_addr;
      end

      ST_READ_OP: begin
        if (r_no_read) begin
          w_state_d = ST_DONE;
        end else begin
          w_req  = 1'b1;
          w_addr = r_eff_addr;
          if (bus.memAck) begin
            w_wait_d    = '0;
            w_operand_d = bus.dataRd;
            w_state_d   = ST_DONE;
          end else if (r_wait == WAIT_LAST) begin
            w_wait_d    = '0;
            w_bus_err_d = 1'b1;
            w_operand_d = '0;
            w_state_d   = ST_DONE;
          end else begin
            w_wait_d = r_wait + 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_state_d = ST_IDLE;
      end

      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpuClk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mode       <= AM_IMP;
      r_no_read    <= 1'b0;
      r_pc         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_lo         <= '0;
      r_wait       <= '0;
      r_operand    <= '0;
      r_eff_addr   <= '0;
      r_pc_out     <= '0;
      r_page_cross <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_mode       <= w_mode_d;
      r_no_read    <= w_no_read_d;
      r_pc         <= w_pc_d;
      r_x          <= w_x_d;
      r_y          <= w_y_d;
      r_lo         <= w_lo_d;
      r_wait       <= w_wait_d;
      r_operand    <= w_operand_d;
      r_eff_addr   <= w_eff_addr_d;
      r_pc_out     <= w_pc_out_d;
      r_page_cross <= w_page_cross_d;
      r_bus_err    <= w_bus_err_d;
    end
  end

  // memReq/memAddr decode from the state register only, so reset drops them at once.
  assign bus.memReq    = w_req;
  assign bus.memAddr   = w_addr;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.operand   = r_operand;
  assign bus.effAddr   = r_eff_addr;
  assign bus.pcOut     = r_pc_out;
  assign bus.pageCross = r_page_cross;
  assign bus.busErr    = r_bus_err;

endmodule

// File: tb/tb_cpu_operand_fetch.sv
module tb_cpu_operand_fetch;
  import cpu_operand_fetch_pkg::*;

  localparam int PAGE_PENALTY = 1;
  localparam int ACK_TIMEOUT  = 15;

  logic clk;
  logic rst;
  int   cyc;
  int   n_err;
  int   n_chk;

  cpu_operand_fetch_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  cpu_operand_fetch #(
    .DATA_W       (8),
    .ADDR_W       (16),
    .PAGE_PENALTY (PAGE_PENALTY),
    .ACK_TIMEOUT  (ACK_TIMEOUT)
  ) dut (
    .cpuClk (clk),
    .reset  (rst),
    .bus    (bus)
  );

  typedef struct {
    int op;
    int eff;
    int pco;
    int lat;
    int start;
    bit pcx;
    bit berr;
    bit skip_eff;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem[0:65535];
  int         cfg_wait;
  bit         cfg_noack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: operand-byte count, page arithmetic and access counting.
  function automatic exp_t model(input int m, input bit nr, input int pc, input int x,
                                 input int y, input int w, input bit na);
    exp_t e;
    int lo, hi, idx, acc, extra, nbytes;
    lo  = int'(mem[16'(pc)]);
    hi  = int'(mem[16'((pc + 1) % 65536)]);
    idx = (m == 3 || m == 6) ? x : ((m == 4 || m == 7) ? y : 0);
    nbytes = (m == 0) ? 0 : ((m <= 4) ? 1 : 2);
    e.pco = (pc + nbytes) % 65536;
    e.op = 0; e.eff = 0; e.pcx = 1'b0; e.berr = 1'b0; e.skip_eff = 1'b0; e.start = 0;
    acc = 0; extra = 0;
    if (m == 0) begin
      e.lat = 1;
    end else if (na) begin
      e.berr = 1'b1;
      e.lat = 1 + ACK_TIMEOUT;
      e.skip_eff = 1'b1;
    end else if (m == 1) begin
      e.op  = lo;
      e.lat = 2 + w;
    end else begin
      if (m <= 4) begin
        e.eff = (lo + idx) % 256;
        acc   = 1;
        extra = (m != 2) ? 1 : 0;
      end else begin
        e.eff = (hi * 256 + lo + idx) % 65536;
        e.pcx = ((e.eff / 256) != hi);
        acc   = 2;
        extra = (e.pcx && PAGE_PENALTY != 0) ? 1 : 0;
      end
      if (!nr) begin
        acc++;
        e.op = int'(mem[16'(e.eff)]);
      end
      e.lat = 1 + acc * (w + 1) + extra;
    end
    return e;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.done) && n < 200);
    if (bus.busy || bus.done) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: busy=%0d after %0d cycles, expected idle", bus.busy, n);
      pulse_reset();
      exp_q.delete();
      @(negedge clk);
    end
  endtask

  task automatic drive_start(input int m, input bit nr, input int pc, input int x, input int y);
    bus.start  = 1'b1;
    bus.mode   = addrmode_t'(3'(m));
    bus.noRead = nr;
    bus.pcIn   = 16'(pc);
    bus.xReg   = 8'(x);
    bus.yReg   = 8'(y);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.xReg   = 8'($urandom);
    bus.yReg   = 8'($urandom);
    bus.pcIn   = 16'($urandom);
  endtask

  task automatic issue(input int m, input bit nr, input int pc, input int x, input int y,
                       input int w, input bit na);
    exp_t e;
    wait_idle();
    cfg_wait  = w;
    cfg_noack = na;
    e = model(m, nr, pc, x, y, w, na);
    e.start = cyc;
    exp_q.push_back(e);
    drive_start(m, nr, pc, x, y);
  endtask

  // Memory responder: cfg_wait wait states per access, random acks outside requests.
  initial begin
    bit         in_req;
    int         wcnt;
    logic [15:0] held;
    in_req = 1'b0; wcnt = 0; held = '0;
    bus.memAck = 1'b0;
    bus.dataRd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.memAck = 1'b0;
        in_req = 1'b0;
        wcnt = 0;
      end else if (bus.memReq) begin
        if (in_req) chk("addr_stable", int'(bus.memAddr), int'(held));
        else begin
          held = bus.memAddr;
          wcnt = 0;
        end
        if (!cfg_noack && wcnt == cfg_wait) begin
          bus.memAck = 1'b1;
          bus.dataRd = mem[bus.memAddr];
          in_req = 1'b0;
        end else begin
          bus.memAck = 1'b0;
          bus.dataRd = 8'($urandom);
          in_req = 1'b1;
          wcnt++;
        end
      end else begin
        in_req = 1'b0;
        wcnt = 0;
        bus.memAck = !cfg_noack && ($urandom_range(0, 3) == 0);
        bus.dataRd = 8'($urandom);
      end
    end
  end

  // Monitor: every done pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc - e.start, e.lat);
          chk("operand", int'(bus.operand), e.op);
          chk("pcOut", int'(bus.pcOut), e.pco);
          chk("busErr", int'(bus.busErr), int'(e.berr));
          if (!e.skip_eff) begin
            chk("effAddr", int'(bus.effAddr), e.eff);
            chk("pageCross", int'(bus.pageCross), int'(e.pcx));
          end
        end
      end
    end
  end

  initial begin
    int m, n;
    bit nr, na, found;
    n_err = 0; n_chk = 0; cyc = 0;
    cfg_wait = 0; cfg_noack = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = AM_IMP; bus.noRead = 1'b0;
    bus.pcIn = '0; bus.xReg = '0; bus.yReg = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    #2;
    chk("rst_memReq", int'(bus.memReq), 0);
    chk("rst_memAddr", int'(bus.memAddr), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_operand", int'(bus.operand), 0);
    chk("rst_effAddr", int'(bus.effAddr), 0);
    chk("rst_pcOut", int'(bus.pcOut), 0);
    chk("rst_flags", int'({bus.pageCross, bus.busErr}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // IMM
    mem[16'h0200] = 8'hA5;
    issue(1, 1'b0, 16'h0200, 0, 0, 0, 1'b0);
    // ZPX wraps inside page 0
    mem[16'h0300] = 8'hF0; mem[16'h0010] = 8'h3C; mem[16'h0110] = 8'hC3;
    issue(3, 1'b0, 16'h0300, 8'h20, 0, 0, 1'b0);
    // ABSX with and without page cross
    mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h12;
    mem[16'h1300] = 8'h77; mem[16'h12FF] = 8'h88;
    issue(6, 1'b0, 16'h0400, 8'h01, 0, 0, 1'b0);
    issue(6, 1'b0, 16'h0400, 8'h00, 0, 0, 1'b0);
    // ABS with 3 wait states per access
    issue(5, 1'b0, 16'h0500, 0, 0, 3, 1'b0);
    // ABS at the top of memory: hi byte wraps to 0x0000
    mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h56;
    issue(5, 1'b0, 16'hFFFF, 0, 0, 0, 1'b0);
    // ABSY store with page cross, and IMP
    issue(7, 1'b1, 16'h0400, 0, 8'h10, 1, 1'b0);
    issue(0, 1'b0, 16'h1234, 0, 0, 0, 1'b0);
    // ZP timeout, then a normal ZP that must clear busErr
    issue(2, 1'b0, 16'h0600, 0, 0, 0, 1'b1);
    issue(2, 1'b0, 16'h0600, 0, 0, 0, 1'b0);

    // Reset during FETCH_HI
    wait_idle();
    cfg_wait = 3; cfg_noack = 1'b0;
    drive_start(5, 1'b0, 16'h4000, 0, 0);
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.memReq && bus.memAddr == 16'h4001) found = 1'b1;
    end
    chk("reach_fetch_hi", int'(found), 1);
    rst = 1'b1;
    #1;
    chk("midrst_memReq", int'(bus.memReq), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(5, 1'b0, 16'h4000, 0, 0, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      m  = int'($urandom_range(0, 7));
      nr = (m >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      na = (m != 0) && ($urandom_range(0, 11) == 0);
      issue(m, nr, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), na);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_operand_fetch.md
Name: cpu_operand_fetch

Overview:
- Multi-cycle operand/effective-address sequencer for the 6502-class core; the next generation of the DECODE→IMM_BYTE path.
- Supports implied, immediate, zero-page (plain/X/Y) and absolute (plain/X/Y) modes.
- Generalised in data width, bus wait states (req/ack handshake with timeout) and optional page-cross penalty cycle.
- Sits between the decode FSM and the memory arbiter; the execute stage consumes operand, effAddr and pcOut on done.

Parameters:
- DATA_W, 8: data/register width; one "page" is 2^DATA_W bytes.
- ADDR_W, 16: address width; must equal 2*DATA_W.
- PAGE_PENALTY, 1: 1 inserts a FIX_PAGE dummy cycle on ABSX/ABSY page cross; 0 omits it.
- ACK_TIMEOUT, 15: maximum cycles memReq may wait for memAck before abort; 4-bit counter (width = clog2(ACK_TIMEOUT+1)).

Ports:
- cpuClk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a fetch; sampled only in IDLE.
- mode, input, 3: addressing mode: 0 IMP, 1 IMM, 2 ZP, 3 ZPX, 4 ZPY, 5 ABS, 6 ABSX, 7 ABSY.
- noRead, input, 1: address-only access (stores); skips READ_OP.
- pcIn, input, ADDR_W: address of first operand byte.
- xReg, input, DATA_W: X index, latched at start.
- yReg, input, DATA_W: Y index, latched at start.
- memReq, output, 1: bus read request.
- memAddr, output, ADDR_W: bus address.
- memAck, input, 1: dataRd valid this cycle; completes the access.
- dataRd, input, DATA_W: read data.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse; result outputs valid.
- operand, output, DATA_W: fetched operand (0 for IMP or noRead).
- effAddr, output, ADDR_W: effective address (0 for IMP/IMM).
- pcOut, output, ADDR_W: pcIn + operand bytes (IMP 0, IMM/ZP* 1, ABS* 2), mod 2^ADDR_W.
- pageCross, output, 1: indexed absolute crossed a page.
- busErr, output, 1: access timed out; valid with done.

Behaviour:
- Reset: state IDLE; all outputs 0; counters and latches 0. Asserting reset mid-operation drops memReq immediately and discards the transaction; no done is produced.
- States: IDLE, FETCH_LO, FETCH_HI, INDEX, FIX_PAGE, READ_OP, DONE.
- IDLE + start: latch mode, noRead, pcIn, xReg, yReg.
  - IMP → DONE.
  - Otherwise → FETCH_LO.
  - start while busy is ignored.
- FETCH_LO: memReq=1, memAddr=pcIn. On ack, latch lo.
  - IMM: operand=dataRd → DONE.
  - ZP → READ_OP.
  - ZPX/ZPY → INDEX.
  - ABS* → FETCH_HI.
- FETCH_HI: memAddr=pcIn+1 (wraps). On ack, latch hi.
  - effAddr = {hi,lo} + zero-extended index (X for ABSX, Y for ABSY, none for ABS), mod 2^ADDR_W.
  - pageCross = high half of effAddr ≠ hi.
  - → FIX_PAGE if pageCross && PAGE_PENALTY; else READ_OP.
- INDEX: one bus-idle cycle. effAddr = {0, (lo+idx) mod 2^DATA_W}; zero page never leaves page 0; pageCross=0. → READ_OP.
- FIX_PAGE: one bus-idle cycle → READ_OP.
- READ_OP: if noRead, go to DONE without a bus access. Otherwise memReq=1, memAddr=effAddr; on ack, operand=dataRd → DONE.
- DONE: done=1 for exactly one cycle; result outputs are held stable until the next start → IDLE.
- Handshake:
  - memReq and memAddr are stable from assertion until the ack cycle.
  - memAck outside a request is ignored.
  - Ack in the same cycle as the request is legal (zero wait).
- Timeout: a wait counter clears on each new request.
  - If ACK_TIMEOUT cycles elapse without ack: busErr=1, operand=0 → DONE.
  - busErr clears at the next start.
- Zero-wait latency, start cycle counted as 0, done cycle:
  - IMP 1; IMM 2; ZP 3; ZPX/ZPY 4; ABS 4.
  - ABSX/ABSY: 4 without page cross; 5 with page cross and PAGE_PENALTY=1.
  - noRead removes one cycle from every mode except IMP and IMM.

Decomposition:
- Add to cpu_types: addrmode_t enum (3-bit, the values above) and fetchstate_t enum.
- Optional sub-module cpu_index_adder: combinational lo/hi + index with zero-page wrap and pageCross. Everything else stays in one always_ff/always_comb FSM pair.

Test Plan:
- IMM, pcIn=0x0200, mem[0x0200]=0xA5, zero wait → done at cycle 2, operand=0xA5, pcOut=0x0201, effAddr=0.
- ZPX, lo=0xF0, X=0x20 → INDEX cycle, read 0x0010 (wrap, not 0x0110), pageCross=0, done at cycle 4.
- ABSX, bytes 0xFF,0x12, X=0x01, PAGE_PENALTY=1 → effAddr=0x1300, pageCross=1, FIX_PAGE seen, done at cycle 5. Same with X=0x00 → effAddr=0x12FF, done at cycle 4.
- ABS with 3 wait states per access → memReq/memAddr held stable through waits; done at cycle 4+9=13; pcOut=pcIn+2. pcIn=0xFFFF → hi byte read from 0x0000, pcOut=0x0001.
- ZP, memAck never asserted, ACK_TIMEOUT=15 → busErr=1 with done after 15 wait cycles; next start clears busErr.
- Reset asserted during FETCH_HI → memReq=0 asynchronously, busy=0, no done; start after reset release → normal operation.
